// File: rtl/ball_mover.sv
// Ball kinematics for the brick game: prescaled stepping, wall reflection, paddle/loss decision.
// Optional brick-collision inputs hit_h/hit_v are compiled in when BALL_HIT_EN is defined.
module ball_mover #(
  parameter int STEP_DIV = 100000,
  parameter int START_X  = 128,
  parameter int START_Y  = 200,
  parameter int PADDLE_Y = 224
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       launch,
  input  logic [2:0] angle,
  input  logic       paddle_hit,
`ifdef BALL_HIT_EN
  input  logic       hit_h,
  input  logic       hit_v,
`endif
  output logic [7:0] ball_x,
  output logic [7:0] ball_y,
  output logic       moving,
  output logic       step,
  output logic       lost
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [7:0] START_X_B = 8'(START_X);
  localparam logic [7:0] START_Y_B = 8'(START_Y);
  localparam logic [7:0] PADDLE_Y_B = 8'(PADDLE_Y);
  localparam logic signed [9:0] PADDLE_Y_S = 10'(PADDLE_Y);

  typedef enum logic [1:0] {IDLE, MOVE, LOST} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [7:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic signed [2:0] dx_q, dx_d;
  logic signed [2:0] dy_q, dy_d;
  logic              step_q, step_d;
  logic              lost_q, lost_d;

  logic signed [2:0] ang_dx, ang_dy;
  logic signed [2:0] eff_dx, eff_dy;
  logic signed [9:0] nx, ny, nx_neg, nx_mir, ny_neg;
  logic              dy_down;

`ifdef BALL_HIT_EN
  logic hflag_q, hflag_d;
  logic vflag_q, vflag_d;
  logic h_pend, v_pend;
  assign h_pend = hflag_q | hit_h;
  assign v_pend = vflag_q | hit_v;
`endif

  always_comb begin
    ang_dx = 3'sb001;
    ang_dy = 3'sb111;
    case (angle)
      3'd0: begin ang_dx = 3'sb110; ang_dy = 3'sb111; end
      3'd1: begin ang_dx = 3'sb111; ang_dy = 3'sb111; end
      3'd2: begin ang_dx = 3'sb111; ang_dy = 3'sb110; end
      3'd3: begin ang_dx = 3'sb001; ang_dy = 3'sb110; end
      3'd5: begin ang_dx = 3'sb010; ang_dy = 3'sb111; end
      default: begin ang_dx = 3'sb001; ang_dy = 3'sb111; end
    endcase
  end

  // Pending brick hits flip direction before the move is computed.
  always_comb begin
    eff_dx = dx_q;
    eff_dy = dy_q;
`ifdef BALL_HIT_EN
    if (h_pend) eff_dx = -dx_q;
    if (v_pend) eff_dy = -dy_q;
`endif
    nx      = {2'b00, x_q} + {{7{eff_dx[2]}}, eff_dx};
    ny      = {2'b00, y_q} + {{7{eff_dy[2]}}, eff_dy};
    nx_neg  = -nx;
    nx_mir  = 10'sd510 - nx;
    ny_neg  = -ny;
    dy_down = !eff_dy[2] && (eff_dy != 3'sb000);
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    step_d  = 1'b0;
    lost_d  = 1'b0;
`ifdef BALL_HIT_EN
    hflag_d = hflag_q;
    vflag_d = vflag_q;
`endif
    case (state_q)
      IDLE, LOST: begin
        if (launch) begin
          state_d = MOVE;
          presc_d = '0;
          x_d     = START_X_B;
          y_d     = START_Y_B;
          dx_d    = ang_dx;
          dy_d    = ang_dy;
`ifdef BALL_HIT_EN
          hflag_d = 1'b0;
          vflag_d = 1'b0;
`endif
        end
      end
      MOVE: begin
`ifdef BALL_HIT_EN
        hflag_d = h_pend;
        vflag_d = v_pend;
`endif
        if (presc_q != PRESC_LAST) begin
          presc_d = presc_q + PW'(1);
        end else if (launch) begin
          // A launch landing on a step cycle swallows that step and restarts the count.
          presc_d = '0;
`ifdef BALL_HIT_EN
          hflag_d = 1'b0;
          vflag_d = 1'b0;
`endif
        end else begin
          presc_d = '0;
          step_d  = 1'b1;
          dx_d    = eff_dx;
          dy_d    = eff_dy;
`ifdef BALL_HIT_EN
          hflag_d = 1'b0;
          vflag_d = 1'b0;
`endif
          if (nx[9]) begin
            x_d  = nx_neg[7:0];
            dx_d = -eff_dx;
          end else if (nx[8]) begin
            x_d  = nx_mir[7:0];
            dx_d = -eff_dx;
          end else begin
            x_d  = nx[7:0];
          end

          if (ny[9]) begin
            y_d  = ny_neg[7:0];
            dy_d = -eff_dy;
          end else if (dy_down && (ny >= PADDLE_Y_S)) begin
            y_d = PADDLE_Y_B;
            if (paddle_hit) begin
              dx_d = ang_dx;
              dy_d = ang_dy;
            end else begin
              state_d = LOST;
              lost_d  = 1'b1;
            end
          end else begin
            y_d = ny[7:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      x_q     <= START_X_B;
      y_q     <= START_Y_B;
      dx_q    <= 3'sb001;
      dy_q    <= 3'sb111;
      step_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      step_q  <= step_d;
      lost_q  <= lost_d;
    end
  end

`ifdef BALL_HIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hflag_q <= 1'b0;
      vflag_q <= 1'b0;
    end else begin
      hflag_q <= hflag_d;
      vflag_q <= vflag_d;
    end
  end
`endif

  assign ball_x = x_q;
  assign ball_y = y_q;
  assign moving = (state_q == MOVE);
  assign step   = step_q;
  assign lost   = lost_q;

endmodule

// File: tb/tb_ball_mover.sv
// Bench for ball_mover: three differently parameterised instances share clock, reset and angle.
module tb_ball_mover;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       launch_a = 1'b0, launch_b = 1'b0, launch_c = 1'b0;
  logic [2:0] angle = 3'd4;
  logic       paddle_hit = 1'b0;

  logic [7:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic       mv_a, st_a, lo_a, mv_b, st_b, lo_b, mv_c, st_c, lo_c;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } pos_t;
  pos_t sb_q[$];

  always #5 clk = ~clk;

  ball_mover #(.STEP_DIV(4)) u_a (
    .clk(clk), .rst(rst), .launch(launch_a), .angle(angle), .paddle_hit(paddle_hit),
`ifdef BALL_HIT_EN
    .hit_h(1'b0), .hit_v(1'b0),
`endif
    .ball_x(x_a), .ball_y(y_a), .moving(mv_a), .step(st_a), .lost(lo_a));

  ball_mover #(.STEP_DIV(1), .START_X(1)) u_b (
    .clk(clk), .rst(rst), .launch(launch_b), .angle(angle), .paddle_hit(paddle_hit),
`ifdef BALL_HIT_EN
    .hit_h(1'b0), .hit_v(1'b0),
`endif
    .ball_x(x_b), .ball_y(y_b), .moving(mv_b), .step(st_b), .lost(lo_b));

  ball_mover #(.STEP_DIV(1), .START_Y(222)) u_c (
    .clk(clk), .rst(rst), .launch(launch_c), .angle(angle), .paddle_hit(paddle_hit),
`ifdef BALL_HIT_EN
    .hit_h(1'b0), .hit_v(1'b0),
`endif
    .ball_x(x_c), .ball_y(y_c), .moving(mv_c), .step(st_c), .lost(lo_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic step_of(input int w);
    case (w)
      0: return st_a;
      1: return st_b;
      default: return st_c;
    endcase
  endfunction

  function automatic pos_t pos_of(input int w);
    case (w)
      0: return {x_a, y_a};
      1: return {x_b, y_b};
      default: return {x_c, y_c};
    endcase
  endfunction

  // Unfolded straight-line travel folded back into the field by the walls.
  function automatic logic [7:0] fold_x(input int p);
    int m;
    m = p % 510;
    if (m < 0) m += 510;
    if (m > 255) m = 510 - m;
    return 8'(m);
  endfunction

  function automatic logic [7:0] fold_y(input int p);
    int v;
    v = (p < 0) ? -p : p;
    return 8'(v);
  endfunction

  task automatic wait_step(input int w, output int ticks, output bit got);
    ticks = 0;
    got   = 1'b0;
    while (!got && ticks < 2000) begin
      tick();
      ticks++;
      if (step_of(w) === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    int steps_seen;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (x_a !== 8'd128 || y_a !== 8'd200 || mv_a !== 1'b0 || st_a !== 1'b0 || lo_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: got x=%0d y=%0d mv=%b st=%b lo=%b, expected x=128 y=200 mv=0 st=0 lo=0",
               x_a, y_a, mv_a, st_a, lo_a);
    end
    rst = 1'b0;
    steps_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (st_a || st_b || st_c || lo_a || lo_b || lo_c) steps_seen++;
    end
    checks++;
    if (steps_seen != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d cycles with step/lost, expected 0", steps_seen);
    end
    checks++;
    if (x_b !== 8'd1 || y_b !== 8'd200 || x_c !== 8'd128 || y_c !== 8'd222 || mv_b || mv_c) begin
      errors++;
      $display("FAIL reset_bc: got b=(%0d,%0d) c=(%0d,%0d) mv=%b%b, expected b=(1,200) c=(128,222) mv=00",
               x_b, y_b, x_c, y_c, mv_b, mv_c);
    end
    $display("reset: a=(%0d,%0d) b=(%0d,%0d) c=(%0d,%0d)", x_a, y_a, x_b, y_b, x_c, y_c);
  endtask

  task automatic test_steps;
    int t;
    bit g;
    pos_t e, o;
    angle = 3'd4;
    launch_a = 1'b1;
    tick();
    launch_a = 1'b0;
    angle = 3'd2;  // must not affect the flight
    checks++;
    if (mv_a !== 1'b1) begin
      errors++;
      $display("FAIL launch_moving: got moving=%b, expected 1", mv_a);
    end
    sb_q.push_back('{8'd129, 8'd199});
    sb_q.push_back('{8'd130, 8'd198});
    sb_q.push_back('{8'd131, 8'd197});
    for (int k = 0; k < 3; k++) begin
      wait_step(0, t, g);
      e = sb_q.pop_front();
      o = pos_of(0);
      checks++;
      if (!g || t != 4 || o !== e) begin
        errors++;
        $display("FAIL step_a%0d: got (%0d,%0d) after %0d cycles, expected (%0d,%0d) after 4",
                 k, o.x, o.y, t, e.x, e.y);
      end
      $display("step_a%0d: (%0d,%0d) after %0d cycles", k, o.x, o.y, t);
    end
  endtask

  task automatic test_launch_on_step;
    int t;
    bit g;
    pos_t e, o;
    repeat (3) tick();
    launch_a = 1'b1;
    tick();
    launch_a = 1'b0;
    checks++;
    if (st_a !== 1'b0 || x_a !== 8'd131 || y_a !== 8'd197 || mv_a !== 1'b1) begin
      errors++;
      $display("FAIL launch_on_step: got st=%b (%0d,%0d) mv=%b, expected st=0 (131,197) mv=1",
               st_a, x_a, y_a, mv_a);
    end
    sb_q.push_back('{8'd132, 8'd196});
    wait_step(0, t, g);
    e = sb_q.pop_front();
    o = pos_of(0);
    checks++;
    if (!g || t != 4 || o !== e) begin
      errors++;
      $display("FAIL step_after_launch: got (%0d,%0d) after %0d cycles, expected (%0d,%0d) after 4",
               o.x, o.y, t, e.x, e.y);
    end
    $display("launch_on_step: next step (%0d,%0d) after %0d cycles", o.x, o.y, t);
  endtask

  task automatic test_async_reset;
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (x_a !== 8'd128 || y_a !== 8'd200 || mv_a !== 1'b0 || st_a !== 1'b0 || lo_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got (%0d,%0d) mv=%b st=%b lo=%b, expected (128,200) mv=0 st=0 lo=0",
               x_a, y_a, mv_a, st_a, lo_a);
    end
    tick();
    rst = 1'b0;
    repeat (6) tick();
    checks++;
    if (mv_a !== 1'b0 || st_a !== 1'b0 || lo_a !== 1'b0 || x_a !== 8'd128) begin
      errors++;
      $display("FAIL post_reset_idle: got mv=%b st=%b lo=%b x=%0d, expected mv=0 st=0 lo=0 x=128",
               mv_a, st_a, lo_a, x_a);
    end
    $display("async_reset: (%0d,%0d) moving=%b", x_a, y_a, mv_a);
  endtask

  task automatic test_wall;
    int t;
    bit g;
    pos_t e, o;
    angle = 3'd0;
    launch_b = 1'b1;
    tick();
    launch_b = 1'b0;
    sb_q.push_back('{8'd1, 8'd199});
    sb_q.push_back('{8'd3, 8'd198});
    sb_q.push_back('{8'd5, 8'd197});
    for (int k = 0; k < 3; k++) begin
      wait_step(1, t, g);
      e = sb_q.pop_front();
      o = pos_of(1);
      checks++;
      if (!g || t != 1 || o !== e) begin
        errors++;
        $display("FAIL wall_b%0d: got (%0d,%0d) after %0d cycles, expected (%0d,%0d) after 1",
                 k, o.x, o.y, t, e.x, e.y);
      end
      $display("wall_b%0d: (%0d,%0d)", k, o.x, o.y);
    end
  endtask

  // Launch u_c up-right from (128,222); it bounces off right, top and left walls and
  // reaches the paddle row on step 446 at (64,224).
  task automatic run_to_paddle(input logic hit, input logic [2:0] post_angle);
    int t;
    bit g;
    pos_t e, o;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    angle = 3'd4;
    paddle_hit = hit;
    launch_c = 1'b1;
    tick();
    launch_c = 1'b0;
    angle = post_angle;
    for (int n = 1; n <= 446; n++) begin
      sb_q.push_back('{fold_x(128 + n), fold_y(222 - n)});
      wait_step(2, t, g);
      e = sb_q.pop_front();
      o = pos_of(2);
      checks++;
      if (!g || t != 1 || o !== e || (n < 446 && lo_c !== 1'b0)) begin
        errors++;
        $display("FAIL flight_c%0d: got (%0d,%0d) lost=%b after %0d cycles, expected (%0d,%0d) lost=0 after 1",
                 n, o.x, o.y, lo_c, t, e.x, e.y);
      end
      $display("flight_c%0d: (%0d,%0d)", n, o.x, o.y);
    end
  endtask

  task automatic test_lost;
    int t;
    bit g;
    pos_t o;
    run_to_paddle(1'b0, 3'd4);
    checks++;
    if (lo_c !== 1'b1 || mv_c !== 1'b0) begin
      errors++;
      $display("FAIL lost_pulse: got lost=%b moving=%b, expected lost=1 moving=0", lo_c, mv_c);
    end
    tick();
    checks++;
    if (lo_c !== 1'b0 || st_c !== 1'b0 || x_c !== 8'd64 || y_c !== 8'd224) begin
      errors++;
      $display("FAIL lost_one_cycle: got lost=%b step=%b (%0d,%0d), expected lost=0 step=0 (64,224)",
               lo_c, st_c, x_c, y_c);
    end
    repeat (5) tick();
    checks++;
    if (mv_c !== 1'b0 || x_c !== 8'd64 || y_c !== 8'd224) begin
      errors++;
      $display("FAIL lost_frozen: got moving=%b (%0d,%0d), expected moving=0 (64,224)", mv_c, x_c, y_c);
    end
    angle = 3'd4;
    launch_c = 1'b1;
    tick();
    launch_c = 1'b0;
    checks++;
    if (mv_c !== 1'b1 || x_c !== 8'd128 || y_c !== 8'd222) begin
      errors++;
      $display("FAIL relaunch: got moving=%b (%0d,%0d), expected moving=1 (128,222)", mv_c, x_c, y_c);
    end
    sb_q.push_back('{8'd129, 8'd221});
    wait_step(2, t, g);
    o = pos_of(2);
    checks++;
    if (!g || t != 1 || o !== sb_q[0]) begin
      errors++;
      $display("FAIL relaunch_step: got (%0d,%0d) after %0d cycles, expected (129,221) after 1", o.x, o.y, t);
    end
    void'(sb_q.pop_front());
    $display("lost: relaunched, first step (%0d,%0d)", o.x, o.y);
  endtask

  task automatic test_paddle_hit(input logic [2:0] a, input logic [7:0] exp_x);
    int t;
    bit g;
    pos_t e, o;
    run_to_paddle(1'b1, a);
    checks++;
    if (lo_c !== 1'b0 || mv_c !== 1'b1) begin
      errors++;
      $display("FAIL paddle_%0d_state: got lost=%b moving=%b, expected lost=0 moving=1", a, lo_c, mv_c);
    end
    sb_q.push_back('{exp_x, 8'd223});
    wait_step(2, t, g);
    e = sb_q.pop_front();
    o = pos_of(2);
    checks++;
    if (!g || t != 1 || o !== e) begin
      errors++;
      $display("FAIL paddle_%0d_bounce: got (%0d,%0d) after %0d cycles, expected (%0d,%0d) after 1",
               a, o.x, o.y, t, e.x, e.y);
    end
    $display("paddle angle %0d: bounce to (%0d,%0d)", a, o.x, o.y);
    paddle_hit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steps();
    test_launch_on_step();
    test_async_reset();
    test_wall();
    test_lost();
    test_paddle_hit(3'd1, 8'd63);
    test_paddle_hit(3'd7, 8'd65);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
